phv_assembler: RTL
==================

// Module: phv_assembler
// PURPOSE
//  Collects the per-cycle extraction results of NUM_SP parallel sub-parsers and packs them into one PHV.
//  Each result is a typed (2B/4B/6B) value plus a 3-bit container sequence; the block sorts results into containers.
//  Pairs each group with packet metadata, buffers finished PHVs, hands them to the stage pipeline via valid/ready.
//  Sits directly downstream of the sub-parser array, upstream of stage 0.
// PARAMETERS
//  NUM_SP        10    number of sub-parser lanes
//  VAL_OUT_LEN   48    width of each lane value bus
//  PHV_META_LEN  256   metadata width carried in PHV LSBs
//  FIFO_DEPTH    4     PHV output FIFO depth (power of 2, >=2)
//  META_DEPTH    4     metadata FIFO depth (power of 2, >=2)
//  PHV_LEN       derived = 8*48+8*32+8*16+PHV_META_LEN (1024 at defaults)
// PORTS
//  clk            in   1                 clock
//  aresetn        in   1                 reset; single clock; asynchronous, active-low
//  meta_in_valid  in   1                 metadata word valid (no backpressure)
//  meta_in        in   PHV_META_LEN      packet metadata
//  val_in_valid   in   NUM_SP            per-lane result valid
//  val_in         in   NUM_SP*48         lane i at [48*i +: 48]
//  val_in_type    in   NUM_SP*2          lane i at [2*i +: 2]: 01=2B, 10=4B, 11=6B, 00=none
//  val_in_seq     in   NUM_SP*3          lane i container index 0..7
//  phv_valid      out  1                 PHV FIFO head valid
//  phv_out        out  PHV_LEN           PHV FIFO head
//  phv_ready      in   1                 downstream accepts head
//  err_no_meta    out  1                 sticky: group arrived with no metadata
//  err_meta_ovf   out  1                 sticky: metadata FIFO overflow
// BEHAVIOUR
//  Reset (async, aresetn=0): FIFOs emptied, pointers zeroed; phv_valid, phv_out, err_* = 0.
//  - Reset mid-transfer discards everything in flight.
//  PHV layout, LSB first:
//  - meta[PHV_META_LEN-1:0].
//  - 2B container k at PHV_META_LEN+16k.
//  - 4B container k at PHV_META_LEN+128+32k.
//  - 6B container k at PHV_META_LEN+384+48k.
//  - Unwritten containers are 0.
//  Group: any cycle with |val_in_valid.
//  - Lanes with valid=0 or type=00 are ignored.
//  - 2B lanes take val[15:0]; 4B lanes take val[31:0].
//  - Two lanes targeting the same type/seq: the higher lane index wins.
//  Metadata: meta_in_valid pushes to the meta FIFO.
//  - A group pops one meta word.
//  - Meta push and group in the same cycle with the meta FIFO empty: the incoming meta bypasses to this group.
//  - Group with no meta available: meta field = 0 and err_no_meta is set.
//  - Meta push when the meta FIFO is full (and no same-cycle pop): word dropped, err_meta_ovf is set.
//  Latency: group at cycle T -> PHV registered in FIFO at edge T+1 -> phv_valid=1 at T+1 if the FIFO was empty.
//  - First-word-fall-through; phv_out is stable while phv_valid && !phv_ready.
//  Handshake: pop on phv_valid && phv_ready.
//  Full FIFO with an incoming group:
//  - phv_ready=1 on that cycle: push and pop both occur, count unchanged.
//  - Otherwise: the group is dropped and its meta is still popped, which keeps meta aligned.
//  Pointers wrap modulo depth; count is log2(depth)+1 bits.
//  Error flags clear only on reset.
// CONFIGURATION
//  PHV_ASM_STATS_EN defined:
//  - adds outputs stat_phv_cnt[31:0] and stat_drop_cnt[15:0].
//  - stat_phv_cnt counts PHVs accepted downstream, wrapping.
//  - stat_drop_cnt counts groups dropped on full, saturating at 16'hFFFF.
//  - Both reset to 0.
//  PHV_ASM_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package phv_pkg:
//  - container counts (8 per type) and widths 16/32/48.
//  - type codes TYPE_2B/4B/6B/NONE.
//  - container base-offset functions and PHV_LEN.
//  Sub-module phv_fifo: parameterised FWFT sync FIFO (WIDTH, DEPTH), async active-low reset, push/pop/full/empty/count.
//  - Instantiated twice: meta FIFO and PHV FIFO.
//  Top level holds the combinational lane-to-container mux, the bypass/error logic and the counters.
// TESTING
//  Single group:
//  - Stimulus: meta=0xA5.., lane0 6B seq2 val=0x112233445566, lane3 2B seq7 val=0xBEEF.
//  - Expected: phv_valid next cycle; 6B[2]=0x112233445566, 2B[7]=0xBEEF, others 0.
//  Collision:
//  - Stimulus: lane1 and lane4 both 4B seq0, values 0x1 and 0x2.
//  - Expected: 4B[0]=0x2.
//  Backpressure:
//  - Stimulus: phv_ready=0, 6 groups sent.
//  - Expected: 4 PHVs stored; 2 dropped (stat_drop_cnt=2 with STATS_EN); the 4 stored drain in order once ready=1.
//  Full with simultaneous pop:
//  - Stimulus: FIFO full, group arrives with phv_ready=1.
//  - Expected: no drop, count stays 4.
//  Meta edge cases:
//  - Stimulus: group with no meta.
//  - Expected: meta field 0, err_no_meta=1.
//  - Stimulus: 5 meta words with no groups.
//  - Expected: err_meta_ovf=1.
//  - Stimulus: meta and group in the same cycle, FIFO empty.
//  - Expected: bypassed meta appears in the PHV.
//  Async reset:
//  - Stimulus: aresetn pulsed low mid-drain (between clock edges).
//  - Expected: phv_valid=0 and err flags=0 immediately; the next group yields a fresh PHV.

Source files
------------

// File: rtl/phv_pkg.sv
// Shared PHV layout definitions for the parser-to-pipeline assembler:
// container counts and widths, lane type codes and container offsets.
package phv_pkg;

  localparam int NUM_CONT = 8;
  localparam int W2B      = 16;
  localparam int W4B      = 32;
  localparam int W6B      = 48;
  localparam int CONT_LEN = NUM_CONT * (W2B + W4B + W6B);

  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_2B   = 2'b01,
    TYPE_4B   = 2'b10,
    TYPE_6B   = 2'b11
  } val_type_e;

  function automatic int phv_len(input int meta_len);
    return meta_len + CONT_LEN;
  endfunction

  function automatic int off_2b(input int meta_len, input int k);
    return meta_len + W2B * k;
  endfunction

  function automatic int off_4b(input int meta_len, input int k);
    return meta_len + NUM_CONT * W2B + W4B * k;
  endfunction

  function automatic int off_6b(input int meta_len, input int k);
    return meta_len + NUM_CONT * (W2B + W4B) + W6B * k;
  endfunction

endpackage

// File: rtl/phv_fifo.sv
// First-word-fall-through synchronous FIFO. A push on a full FIFO is
// accepted only when a pop happens in the same cycle; dout reads 0 while
// empty so an idle head never shows stale data.
module phv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because dout is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phv_assembler.sv
// Packs one cycle of sub-parser lane results plus a metadata word into a PHV
// and queues it for stage 0.
// Optional build macro PHV_ASM_STATS_EN adds accepted/dropped PHV counters.
// Handshake: phv_valid is the FIFO head valid; a PHV transfers on any edge
// where phv_valid && phv_ready; phv_out holds steady while waiting. Lane and
// metadata inputs have no backpressure: they are sampled on every edge.
module phv_assembler
  import phv_pkg::*;
#(
  parameter int NUM_SP       = 10,
  parameter int VAL_OUT_LEN  = 48,
  parameter int PHV_META_LEN = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int META_DEPTH   = 4,
  localparam int PHV_LEN     = phv_len(PHV_META_LEN)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          meta_in_valid,
  input  logic [PHV_META_LEN-1:0]       meta_in,
  input  logic [NUM_SP-1:0]             val_in_valid,
  input  logic [NUM_SP*VAL_OUT_LEN-1:0] val_in,
  input  logic [NUM_SP*2-1:0]           val_in_type,
  input  logic [NUM_SP*3-1:0]           val_in_seq,
  output logic                          phv_valid,
  output logic [PHV_LEN-1:0]            phv_out,
  input  logic                          phv_ready,
`ifdef PHV_ASM_STATS_EN
  output logic [31:0]                   stat_phv_cnt,
  output logic [15:0]                   stat_drop_cnt,
`endif
  output logic                          err_no_meta,
  output logic                          err_meta_ovf
);

  logic                     group;
  logic [W2B-1:0]           c2 [NUM_CONT];
  logic [W4B-1:0]           c4 [NUM_CONT];
  logic [W6B-1:0]           c6 [NUM_CONT];
  logic [PHV_LEN-1:0]       phv_word;

  logic                     meta_push, meta_pop, meta_bypass;
  logic                     meta_full, meta_empty;
  logic [PHV_META_LEN-1:0]  meta_head, meta_sel;
  logic [$clog2(META_DEPTH):0] unused_meta_count;

  logic                     phv_full, phv_empty, phv_pop, drop;
  logic [$clog2(FIFO_DEPTH):0] unused_phv_count;

  assign group = |val_in_valid;

  // Lane-to-container mux: lanes are scanned upward so the highest lane wins.
  always_comb begin
    logic [2:0]     lane_seq;
    logic [W6B-1:0] lane_val;
    lane_seq = '0;
    lane_val = '0;
    for (int k = 0; k < NUM_CONT; k++) begin
      c2[k] = '0;
      c4[k] = '0;
      c6[k] = '0;
    end
    for (int i = 0; i < NUM_SP; i++) begin
      lane_seq = val_in_seq[3*i +: 3];
      lane_val = val_in[VAL_OUT_LEN*i +: W6B];
      if (val_in_valid[i]) begin
        case (val_type_e'(val_in_type[2*i +: 2]))
          TYPE_2B: c2[lane_seq] = lane_val[W2B-1:0];
          TYPE_4B: c4[lane_seq] = lane_val[W4B-1:0];
          TYPE_6B: c6[lane_seq] = lane_val;
          default: ;
        endcase
      end
    end
  end

  // Metadata selection: FIFO head first, else same-cycle bypass, else zero.
  assign meta_bypass = group && meta_in_valid && meta_empty;
  assign meta_pop    = group && !meta_empty;
  assign meta_push   = meta_in_valid && !meta_bypass;
  assign meta_sel    = !meta_empty ? meta_head : (meta_bypass ? meta_in : '0);

  // PHV image: metadata in the LSBs, then 2B, 4B and 6B container banks.
  always_comb begin
    phv_word = '0;
    phv_word[PHV_META_LEN-1:0] = meta_sel;
    for (int k = 0; k < NUM_CONT; k++) begin
      phv_word[off_2b(PHV_META_LEN, k) +: W2B] = c2[k];
      phv_word[off_4b(PHV_META_LEN, k) +: W4B] = c4[k];
      phv_word[off_6b(PHV_META_LEN, k) +: W6B] = c6[k];
    end
  end

  phv_fifo #(.WIDTH(PHV_META_LEN), .DEPTH(META_DEPTH)) u_meta_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (meta_push),
    .din     (meta_in),
    .pop     (meta_pop),
    .dout    (meta_head),
    .full    (meta_full),
    .empty   (meta_empty),
    .count   (unused_meta_count)
  );

  assign phv_valid = !phv_empty;
  assign phv_pop   = phv_valid && phv_ready;
  // A group meeting a full FIFO is lost unless the head leaves this cycle;
  // its metadata was still consumed above so later groups stay aligned.
  assign drop      = group && phv_full && !phv_ready;

  phv_fifo #(.WIDTH(PHV_LEN), .DEPTH(FIFO_DEPTH)) u_phv_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push    (group),
    .din     (phv_word),
    .pop     (phv_pop),
    .dout    (phv_out),
    .full    (phv_full),
    .empty   (phv_empty),
    .count   (unused_phv_count)
  );

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_no_meta  <= 1'b0;
      err_meta_ovf <= 1'b0;
    end else begin
      if (group && meta_empty && !meta_in_valid) err_no_meta <= 1'b1;
      if (meta_push && meta_full && !meta_pop)   err_meta_ovf <= 1'b1;
    end
  end

`ifdef PHV_ASM_STATS_EN
  // Accepted PHVs wrap; drops saturate so a long stall stays visible.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_phv_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (phv_pop) stat_phv_cnt <= stat_phv_cnt + 32'd1;
      if (drop && stat_drop_cnt != 16'hFFFF) stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif

endmodule
